// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    // Default operand/sum width.
    localparam int DEFAULT_WIDTH = 8;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Single-bit combinational full adder.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic c
);

    // Sum and carry of three input bits.
    always_comb begin
        s = a ^ b ^ cin;
        c = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, one operand bit per clock, LSB first.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIn,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             C
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_reg;
    logic [WIDTH-1:0] shift_a_reg;
    logic [WIDTH-1:0] shift_b_reg;
    logic [WIDTH-1:0] s_reg;
    logic             carry_reg;
    logic             c_reg;
    logic [CW-1:0]    cnt_reg;
    logic             busy_reg;
    logic             done_reg;

    logic             cell_s;
    logic             cell_c;

    // The one adder cell sees the current LSBs and the carry from the previous bit.
    fa_cell u_cell (
        .a   (shift_a_reg[0]),
        .b   (shift_b_reg[0]),
        .cin (carry_reg),
        .s   (cell_s),
        .c   (cell_c)
    );

    // Sequencer: capture operands, shift one bit per cycle, flag completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            shift_a_reg <= '0;
            shift_b_reg <= '0;
            s_reg       <= '0;
            carry_reg   <= 1'b0;
            c_reg       <= 1'b0;
            cnt_reg     <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        shift_a_reg <= A;
                        shift_b_reg <= B;
                        carry_reg   <= CIn;
                        cnt_reg     <= '0;
                        s_reg       <= '0;
                        c_reg       <= 1'b0;
                        busy_reg    <= 1'b1;
                        state_reg   <= RUN;
                    end
                end
                RUN: begin
                    // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
                    s_reg       <= {cell_s, s_reg[WIDTH-1:1]};
                    carry_reg   <= cell_c;
                    shift_a_reg <= {1'b0, shift_a_reg[WIDTH-1:1]};
                    shift_b_reg <= {1'b0, shift_b_reg[WIDTH-1:1]};
                    cnt_reg     <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_LAST) begin
                        c_reg     <= cell_c;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign S    = s_reg;
    assign C    = c_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: per-cycle reference model plus directed cases.
`timescale 1ns/1ps
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             CIn;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] S;
    logic             C;

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .CIn   (CIn),
        .busy  (busy),
        .done  (done),
        .S     (S),
        .C     (C)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted start yields A+B+CIn after WIDTH cycles of work.
    logic             m_busy;
    logic             m_done;
    int               m_cnt;
    logic [WIDTH:0]   m_sum;
    logic [WIDTH-1:0] m_s;
    logic             m_c;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_cnt  <= 0;
            m_sum  <= '0;
            m_s    <= '0;
            m_c    <= 1'b0;
        end else if (!m_busy) begin
            m_done <= 1'b0;
            if (start) begin
                m_busy <= 1'b1;
                m_cnt  <= 0;
                m_sum  <= {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, CIn};
                m_s    <= '0;
                m_c    <= 1'b0;
            end
        end else begin
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == WIDTH) begin
                m_done <= 1'b1;
                m_s    <= m_sum[WIDTH-1:0];
                m_c    <= m_sum[WIDTH];
            end else if (m_cnt + 1 == WIDTH + 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b0;
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", {31'b0, busy}, {31'b0, m_busy});
            check("done", {31'b0, done}, {31'b0, m_done});
            if (!m_busy || m_done) begin
                check("S", {24'b0, S}, {24'b0, m_s});
                check("C", {31'b0, C}, {31'b0, m_c});
            end
            if (done) begin
                txn++;
                $display("txn %0d S=%02h C=%0b", txn, S, C);
            end
        end
    end

    // One directed addition from IDLE; optionally pokes start mid-run.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                          input logic [7:0] es, input logic ec, input bit poke);
        int cyc;
        int extra;
        A = a; B = b; CIn = ci; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 40) begin
            if (poke && cyc == 3) begin
                start = 1'b1; A = 8'h55; B = 8'h55;
            end else if (poke && cyc == 4) begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("latency", cyc, WIDTH + 1);
        check("S_lit", {24'b0, S}, {24'b0, es});
        check("C_lit", {31'b0, C}, {31'b0, ec});
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) extra++;
        end
        check("single_done", extra, 0);
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0; start = 1'b0; A = '0; B = '0; CIn = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_S", {24'b0, S}, 32'h00);
        check("rst_C", {31'b0, C}, 32'd0);

        run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
        run_op(8'h21, 8'h43, 1'b1, 8'h65, 1'b0, 1'b1);

        // Abort mid-run with reset.
        A = 8'h12; B = 8'h34; CIn = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_S", {24'b0, S}, 32'd0);
        check("abort_C", {31'b0, C}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("abort_nodone", {31'b0, done}, 32'd0);
        end
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

        // Back-to-back random operations with start held high.
        start = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            cyc = 0;
            do begin
                A = WIDTH'($urandom);
                B = WIDTH'($urandom);
                CIn = 1'($urandom_range(0, 1));
                @(negedge clk);
                cyc++;
            end while (!done && cyc < 40);
            if (!done) check("timeout", 32'd0, 32'd1);
            if (i > 0) check("period", cyc, WIDTH + 2);
        end
        start = 1'b0;
        repeat (15) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
